// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store unit driving a word-wide data memory.
// Byte-addressed requests become word reads, writes or read-modify-writes on big-endian lanes.
module mem_access_ctrl #(
    parameter int MEM_WORDS = 1048576,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read_wire,
    output logic              mem_write_wire,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t      r_state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_offset;
    logic [31:0] r_wdata;

    logic [ADDR_W-1:0] w_index;
    logic              w_err;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;
    logic [31:0]       w_merge;

    assign w_index = req_addr >> 2;
    assign w_err   = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                  || (w_index >= ADDR_W'(MEM_WORDS));

    // Lane select and merge work on the latched request, so outputs never see req_* directly.
    // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
    always_comb begin
        case (r_offset)
            2'd0:    w_byte = mem_read_data[31:24];
            2'd1:    w_byte = mem_read_data[23:16];
            2'd2:    w_byte = mem_read_data[15:8];
            default: w_byte = mem_read_data[7:0];
        endcase
        w_half = r_offset[1] ? mem_read_data[15:0] : mem_read_data[31:16];

        case (r_size)
            2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = mem_read_data;
        endcase

        w_merge = mem_read_data;
        if (r_size == 2'b00) begin
            case (r_offset)
                2'd0:    w_merge[31:24] = r_wdata[7:0];
                2'd1:    w_merge[23:16] = r_wdata[7:0];
                2'd2:    w_merge[15:8]  = r_wdata[7:0];
                default: w_merge[7:0]   = r_wdata[7:0];
            endcase
        end else if (r_size == 2'b01) begin
            if (r_offset[1]) w_merge[15:0]  = r_wdata[15:0];
            else             w_merge[31:16] = r_wdata[15:0];
        end
    end

    // NOTE: state and outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= 32'd0;
            mem_address    <= '0;
            mem_read_wire  <= 1'b0;
            mem_write_wire <= 1'b0;
            mem_write_data <= 32'd0;
            r_write        <= 1'b0;
            r_size         <= 2'b00;
            r_signed       <= 1'b0;
            r_offset       <= 2'b00;
            r_wdata        <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready   <= 1'b0;
                        r_write     <= req_write;
                        r_size      <= req_size;
                        r_signed    <= req_signed;
                        r_offset    <= req_addr[1:0];
                        r_wdata     <= req_wdata;
                        mem_address <= w_index;
                        if (w_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                            r_state    <= RESP;
                        end else if (req_write && req_size == 2'b10) begin
                            mem_write_wire <= 1'b1;
                            mem_write_data <= req_wdata;
                            r_state        <= WR;
                        end else begin
                            mem_read_wire <= 1'b1;
                            r_state       <= RD;
                        end
                    end
                end
                RD: begin
                    mem_read_wire <= 1'b0;
                    r_state       <= CAP;
                end
                CAP: begin
                    if (r_write) begin
                        mem_write_wire <= 1'b1;
                        mem_write_data <= w_merge;
                        r_state        <= WR;
                    end else begin
                        resp_rdata <= w_load;
                        resp_valid <= 1'b1;
                        r_state    <= RESP;
                    end
                end
                WR: begin
                    mem_write_wire <= 1'b0;
                    resp_valid     <= 1'b1;
                    r_state        <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized checks of mem_access_ctrl against a
// transaction-level model of byte/half/word loads and stores on a big-endian word memory.
module tb_mem_access_ctrl;

    localparam int MEM_WORDS = 1048576;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_address;
    logic        mem_read_wire;
    logic        mem_write_wire;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] dmem    [256];
    logic [31:0] ref_mem [256];

    mem_access_ctrl #(.MEM_WORDS(MEM_WORDS), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .mem_address(mem_address),
        .mem_read_wire(mem_read_wire), .mem_write_wire(mem_write_wire),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // data_mem: read on posedge, write on negedge
    always @(posedge clk) if (mem_read_wire) mem_read_data <= dmem[mem_address[7:0]];
    always @(negedge clk) if (mem_write_wire) dmem[mem_address[7:0]] = mem_write_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          err;
        bit          is_load;
        int          lat;
        int          rd_cyc;
        int          wr_cyc;
        logic [31:0] idx;
        logic [31:0] rdata;
        logic [31:0] wdata;
    } exp_t;

    // Transaction outcome from the addressing rules: lanes located by shift/mask arithmetic.
    function automatic exp_t model(input bit w, input logic [1:0] sz, input bit sg,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] word);
        exp_t e;
        int nb, sh;
        longint unsigned mask, lane, w64;
        e.idx     = a >> 2;
        e.is_load = !w;
        e.err     = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
                    (sz == 2'd2 && a[1:0] != 2'd0) || (e.idx >= 32'(MEM_WORDS));
        e.rdata   = 32'd0;
        e.wdata   = 32'd0;
        if (e.err) begin
            e.lat = 1; e.rd_cyc = 0; e.wr_cyc = 0;
            return e;
        end
        nb   = 1 << sz;
        sh   = 8 * (4 - nb - int'(a[1:0]));
        mask = (64'd1 << (8 * nb)) - 64'd1;
        w64  = {32'd0, word};
        lane = (w64 >> sh) & mask;
        if (sg && nb < 4 && lane[8 * nb - 1]) lane = lane | ~mask;
        e.rdata = lane[31:0];
        lane    = (w64 & ~(mask << sh)) | (({32'd0, wd} & mask) << sh);
        e.wdata = lane[31:0];
        if (w && sz == 2'd2) e.lat = 2;
        else if (!w)         e.lat = 3;
        else                 e.lat = 4;
        e.rd_cyc = (w && sz == 2'd2) ? 0 : 1;
        e.wr_cyc = w ? e.lat - 1 : 0;
        return e;
    endfunction

    // Cycle-by-cycle comparison of every DUT output against the model.
    initial begin : compare
        exp_t        cur;
        int          k;
        bit          active, was_active;
        logic [31:0] last_rdata;
        active = 0; k = 0; last_rdata = 32'd0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                active = 0;
                last_rdata = 32'd0;
            end else begin
                was_active = active;
                if (active) begin
                    if (k == cur.lat) active = 0;
                    else k++;
                end
                if (!was_active && req_valid) begin
                    cur = model(req_write, req_size, req_signed, req_addr, req_wdata,
                                ref_mem[req_addr[9:2]]);
                    active = 1;
                    k = 1;
                end
            end
            @(negedge clk);
            if (rst_n) begin
                if (active) begin
                    check("ready_busy", 32'(req_ready), 32'd0);
                    check("rd_wire", 32'(mem_read_wire), 32'(k == cur.rd_cyc));
                    check("wr_wire", 32'(mem_write_wire), 32'(k == cur.wr_cyc));
                    if (k == cur.rd_cyc || k == cur.wr_cyc)
                        check("mem_addr", mem_address, cur.idx);
                    if (k == cur.wr_cyc) begin
                        check("wr_data", mem_write_data, cur.wdata);
                        ref_mem[cur.idx[7:0]] = cur.wdata;
                    end
                    check("resp_valid", 32'(resp_valid), 32'(k == cur.lat));
                    if (k == cur.lat) begin
                        if (cur.err)          last_rdata = 32'd0;
                        else if (cur.is_load) last_rdata = cur.rdata;
                        check("resp_err", 32'(resp_err), 32'(cur.err));
                        check("resp_rdata", resp_rdata, last_rdata);
                    end
                end else begin
                    check("ready_idle", 32'(req_ready), 32'd1);
                    check("idle_resp_valid", 32'(resp_valid), 32'd0);
                    check("idle_rd_wire", 32'(mem_read_wire), 32'd0);
                    check("idle_wr_wire", 32'(mem_write_wire), 32'd0);
                    check("idle_rdata_held", resp_rdata, last_rdata);
                end
            end
        end
    end

    task automatic do_req(input bit w, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rdata, output bit err, output int lat,
                          output int n_rd, output int n_wr, output logic [31:0] wdat,
                          output logic [31:0] waddr, output bit ready_hi);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; n_rd = 0; n_wr = 0; ready_hi = 0; err = 0;
        rdata = 32'd0; wdat = 32'd0; waddr = 32'd0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (mem_read_wire) n_rd++;
            if (mem_write_wire) begin
                n_wr++;
                wdat  = mem_write_data;
                waddr = mem_address;
            end
            if (req_ready) ready_hi = 1;
            if (resp_valid) begin
                lat   = c;
                rdata = resp_rdata;
                err   = resp_err;
            end
        end
        check("resp_seen", 32'(lat != 0), 32'd1);
    endtask

    task automatic dir(input string nm, input bit w, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                       input bit exp_err, input int exp_lat, input int exp_nrd,
                       input int exp_nwr, input logic [31:0] exp_wdat);
        logic [31:0] rdata, wdat, waddr;
        bit err, ready_hi;
        int lat, n_rd, n_wr;
        do_req(w, sz, sg, a, wd, rdata, err, lat, n_rd, n_wr, wdat, waddr, ready_hi);
        check($sformatf("%s_lat", nm), 32'(lat), 32'(exp_lat));
        check($sformatf("%s_err", nm), 32'(err), 32'(exp_err));
        check($sformatf("%s_nrd", nm), 32'(n_rd), 32'(exp_nrd));
        check($sformatf("%s_nwr", nm), 32'(n_wr), 32'(exp_nwr));
        check($sformatf("%s_ready_low", nm), 32'(ready_hi), 32'd0);
        if (!w) check($sformatf("%s_rdata", nm), rdata, exp_rd);
        if (exp_nwr != 0) begin
            check($sformatf("%s_wdata", nm), wdat, exp_wdat);
            check($sformatf("%s_waddr", nm), waddr, a >> 2);
        end
    endtask

    initial begin : main
        logic [31:0] idx;
        logic [1:0]  off;
        for (int i = 0; i < 256; i++) begin
            dmem[i]    = $urandom;
            ref_mem[i] = dmem[i];
        end
        dmem[4]    = 32'h812345F6;
        ref_mem[4] = 32'h812345F6;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_rd_wire", 32'(mem_read_wire), 32'd0);
        check("rst_wr_wire", 32'(mem_write_wire), 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_wdata", mem_write_data, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        #1 rst_n = 1'b1;

        //   name    w  sz     sg  addr           wdata          exp_rdata      err lat rd wr exp_wdata
        dir("lw",    0, 2'd2, 0, 32'h10,        32'h0,         32'h812345F6, 0, 3, 1, 0, 32'h0);
        dir("lb",    0, 2'd0, 1, 32'h13,        32'h0,         32'hFFFFFFF6, 0, 3, 1, 0, 32'h0);
        dir("lbu",   0, 2'd0, 0, 32'h13,        32'h0,         32'h000000F6, 0, 3, 1, 0, 32'h0);
        dir("lh",    0, 2'd1, 1, 32'h10,        32'h0,         32'hFFFF8123, 0, 3, 1, 0, 32'h0);
        dir("lhu",   0, 2'd1, 0, 32'h12,        32'h0,         32'h000045F6, 0, 3, 1, 0, 32'h0);
        dir("sh",    1, 2'd1, 0, 32'h12,        32'h0000BEEF,  32'h0,        0, 4, 1, 1, 32'h8123BEEF);
        dir("sw4",   1, 2'd2, 0, 32'h10,        32'h812345F6,  32'h0,        0, 2, 0, 1, 32'h812345F6);
        dir("sb",    1, 2'd0, 0, 32'h11,        32'h000000AB,  32'h0,        0, 4, 1, 1, 32'h81AB45F6);
        dir("lw_sb", 0, 2'd2, 0, 32'h10,        32'h0,         32'h81AB45F6, 0, 3, 1, 0, 32'h0);
        dir("sw5",   1, 2'd2, 0, 32'h14,        32'hDEADBEEF,  32'h0,        0, 2, 0, 1, 32'hDEADBEEF);
        dir("e_lw",  0, 2'd2, 0, 32'h12,        32'h0,         32'h0,        1, 1, 0, 0, 32'h0);
        dir("e_lh",  0, 2'd1, 0, 32'h11,        32'h0,         32'h0,        1, 1, 0, 0, 32'h0);
        dir("e_sz",  0, 2'd3, 0, 32'h10,        32'h0,         32'h0,        1, 1, 0, 0, 32'h0);
        dir("e_rng", 0, 2'd2, 0, 32'h00400000,  32'h0,         32'h0,        1, 1, 0, 0, 32'h0);
        check("dmem5", dmem[5], 32'hDEADBEEF);

        // Reset in the first half of the WR cycle of sb 0x10 must suppress the write.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h00000055;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_wr_before", 32'(mem_write_wire), 32'd1);
        check("rst_wr_data", mem_write_data, 32'h55AB45F6);
        #1 rst_n = 1'b0;
        #1;
        check("rst_wr_drop", 32'(mem_write_wire), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_resp", 32'(resp_valid), 32'd0);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_word4", dmem[4], 32'h81AB45F6);
        check("rst_release_ready", 32'(req_ready), 32'd1);
        check("rst_release_resp", 32'(resp_valid), 32'd0);

        // Random phase: inputs change every cycle, including while busy.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) idx = $urandom_range(32'h100000, 32'h3FFFFFFF);
            else                            idx = $urandom_range(0, 63);
            req_size = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0)  off = 2'($urandom_range(0, 3));
            else if (req_size == 2'd2)      off = 2'd0;
            else if (req_size == 2'd1)      off = {1'($urandom_range(0, 1)), 1'b0};
            else                            off = 2'($urandom_range(0, 3));
            req_valid  = ($urandom_range(0, 2) != 0);
            req_write  = 1'($urandom_range(0, 1));
            req_signed = 1'($urandom_range(0, 1));
            req_addr   = {idx[29:0], off};
            req_wdata  = $urandom;
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 64; i++) check($sformatf("mem_word%0d", i), dmem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
